rr_mux_arbiter: RTL and testbench

- Two-requester round-robin arbiter that owns the select line of a shared N-bit 2:1 datapath mux.
- Hands one downstream port (e.g. the Bloom-filter bit-array write port) to requester A or B for whole multi-beat bursts.
- Burst boundaries are marked by last_x.
- Registered grant state; the data path stays combinational through the mux.

---
 rtl/rr_mux_arbiter_pkg.sv | 13 +
 rtl/mux_n.sv | 13 +
 rtl/rr_mux_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared arbiter definitions: grant-state encodings and priority values.
package arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_e;

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

endpackage

// File: rtl/mux_n.sv
// Gate-library N-bit 2:1 mux: y = a when sel is high, otherwise b.
module mux_n #(
  parameter int N = 32
) (
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin burst arbiter driving the select of a shared 2:1 datapath mux.
// Define ARB_BURST_LIMIT_EN to cap each grant at MAX_BEATS transfers.
module rr_mux_arbiter
  import arb_defs::*;
#(
  parameter int N         = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         last_a,
  input  logic [N-1:0] data_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic         last_b,
  input  logic [N-1:0] data_b,
  output logic         ack_b,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         out_last,
  output logic [N-1:0] out_data,
  output logic         grant_a,
  output logic         grant_b,
  output logic         busy
);

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   burst_end;
  logic   limit_hit;
  logic   rel_grant;

  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_max_beats_illegal
    $error("rr_mux_arbiter: MAX_BEATS must be in 1..255");
  end

  assign grant_a = (state_q == GNT_A);
  assign grant_b = (state_q == GNT_B);
  assign busy    = grant_a | grant_b;

  assign ack_a     = grant_a & req_a & out_ready;
  assign ack_b     = grant_b & req_b & out_ready;
  assign out_valid = (grant_a & req_a) | (grant_b & req_b);
  assign out_last  = (grant_a & req_a & last_a) | (grant_b & req_b & last_b);

  assign burst_end = (ack_a & last_a) | (ack_b & last_b);
  assign rel_grant = burst_end | limit_hit;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] LAST_BEAT_IDX = 8'(MAX_BEATS - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       xfer;

  assign xfer      = ack_a | ack_b;
  assign limit_hit = xfer & (cnt_q == LAST_BEAT_IDX);

  // Counter restarts on every grant entry, so it is held at zero outside a grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || rel_grant) begin
      cnt_d = 8'd0;
    end else if (xfer) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // A released grant hands straight to a waiting peer, so there is no idle bubble.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = (prio_q == PRIO_B) ? GNT_B : GNT_A;
        end else if (req_a) begin
          state_d = GNT_A;
        end else if (req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (rel_grant) begin
          prio_d  = PRIO_B;
          state_d = req_b ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (rel_grant) begin
          prio_d  = PRIO_A;
          state_d = req_a ? GNT_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= PRIO_A;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  mux_n #(.N(N)) u_mux (
    .sel (grant_a),
    .a   (data_a),
    .b   (data_b),
    .y   (out_data)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (burst-limit scenario runs when ARB_BURST_LIMIT_EN is defined).
module tb_rr_mux_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, last_a, req_b, last_b, out_ready;
  logic [N-1:0] data_a, data_b;
  logic         ack_a, ack_b, out_valid, out_last, grant_a, grant_b, busy;
  logic [N-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux_arbiter #(.N(N), .MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .last_a    (last_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .last_b    (last_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = 0; last_a = 0; req_b = 0; last_b = 0; out_ready = 1;
    data_a = 32'hAAAA_0000; data_b = 32'hBBBB_0000;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    req_a = 1; last_a = 1; req_b = 1; last_b = 1; out_ready = 1;
    data_a = 32'h1111_1111; data_b = 32'h2222_2222;
    rst = 1;
    #2;
    n_checks++;
    if ({grant_a, grant_b, busy, ack_a, ack_b, out_valid, out_last} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 0000000",
               {grant_a, grant_b, busy, ack_a, ack_b, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h, want 22222222", out_data);
    end
    rst = 0;
    req_a = 0; req_b = 0; last_a = 0; last_b = 0;
  endtask

  task automatic test_single_beat();
    do_reset();
    req_a = 1; last_a = 1; data_a = 32'hCAFE_0001;
    #1;
    n_checks++;
    if (ack_a !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_transfer: ack_a=%b out_valid=%b, want 0 0", ack_a, out_valid);
    end
    tick();
    n_checks++;
    if ({grant_a, grant_b, ack_a, out_valid, out_last, busy} !== 6'b101111) begin
      n_fail++;
      $display("FAIL single_grant: ga gb ack_a ov ol busy=%b, want 101111",
               {grant_a, grant_b, ack_a, out_valid, out_last, busy});
    end
    n_checks++;
    if (out_data !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL single_data: got %h, want cafe0001", out_data);
    end
    tick();
    req_a = 0; last_a = 0;
    n_checks++;
    if ({grant_a, grant_b, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_release: ga gb busy=%b, want 000", {grant_a, grant_b, busy});
    end
    // prio now favours B: a tie must go to B
    req_a = 1; last_a = 1; req_b = 1; last_b = 1;
    tick();
    n_checks++;
    if ({grant_a, grant_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_toggle_b: ga gb=%b, want 01", {grant_a, grant_b});
    end
    tick();
    req_b = 0;
    n_checks++;
    if ({grant_a, grant_b, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL handover_a: ga gb busy=%b, want 101", {grant_a, grant_b, busy});
    end
    tick();
    req_a = 0; last_a = 0; last_b = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handover_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_a = 1; req_b = 1; out_ready = 1;
    data_a = 32'hA5A5_A5A5; data_b = 32'h5A5A_5A5A;
    for (int c = 1; c <= 12; c++) begin
      tick();
      last_a = ((c - 1) % 3 == 2);
      last_b = ((c - 1) % 3 == 2);
      #1;
      n_checks++;
      if (((c - 1) / 3) % 2 == 0) begin
        if ({grant_a, grant_b, busy} !== 3'b101 || out_data !== 32'hA5A5_A5A5) begin
          n_fail++;
          $display("FAIL b2b_cycle%0d: ga gb busy=%b data=%h, want 101 a5a5a5a5",
                   c, {grant_a, grant_b, busy}, out_data);
        end
      end else begin
        if ({grant_a, grant_b, busy} !== 3'b011 || out_data !== 32'h5A5A_5A5A) begin
          n_fail++;
          $display("FAIL b2b_cycle%0d: ga gb busy=%b data=%h, want 011 5a5a5a5a",
                   c, {grant_a, grant_b, busy}, out_data);
        end
      end
    end
    req_a = 0; req_b = 0; last_a = 0; last_b = 0;
  endtask

  task automatic test_stall();
    do_reset();
    req_b = 1; last_b = 0; data_b = 32'hBEEF_0002;
    tick();
    tick();
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({ack_b, grant_b, out_valid} !== 3'b011 || out_data !== 32'hBEEF_0002) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: ack_b gb ov=%b data=%h, want 011 beef0002",
                 c, {ack_b, grant_b, out_valid}, out_data);
      end
      tick();
    end
    out_ready = 1; last_b = 1;
    #1;
    n_checks++;
    if ({ack_b, grant_b, out_last} !== 3'b111) begin
      n_fail++;
      $display("FAIL stall_resume: ack_b gb ol=%b, want 111", {ack_b, grant_b, out_last});
    end
    tick();
    req_b = 0; last_b = 0;
    n_checks++;
    if (grant_b !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: grant_b=%b, want 0", grant_b);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req_a = 1; last_a = 0; req_b = 1; last_b = 0;
    tick();
    tick();
    req_a = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({grant_a, grant_b, out_valid, ack_a, ack_b} !== 5'b10000) begin
        n_fail++;
        $display("FAIL drop_cycle%0d: ga gb ov ack_a ack_b=%b, want 10000",
                 c, {grant_a, grant_b, out_valid, ack_a, ack_b});
      end
      tick();
    end
    req_a = 1; last_a = 1;
    tick();
    req_a = 0; last_a = 0;
    n_checks++;
    if ({grant_a, grant_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_handover: ga gb=%b, want 01", {grant_a, grant_b});
    end
    req_b = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_a = 1; last_a = 0;
    tick();
    #2;
    rst = 1;
    #1;
    n_checks++;
    if ({grant_a, ack_a, out_valid, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: ga ack_a ov busy=%b, want 0000",
               {grant_a, ack_a, out_valid, busy});
    end
    @(negedge clk);
    rst = 0;
    req_a = 1; req_b = 1;
    tick();
    n_checks++;
    if ({grant_a, grant_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_prio_a: ga gb=%b, want 10", {grant_a, grant_b});
    end
    req_a = 0; req_b = 0;
  endtask

`ifdef ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    logic exp_a [1:10];
    int beat_a, beat_b;
    exp_a = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    do_reset();
    beat_a = 0; beat_b = 0;
    data_a = 32'hA000_0000; data_b = 32'hB000_0000;
    req_a = 1; last_a = 0; req_b = 1; last_b = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      data_a = 32'hA000_0000 + 32'(beat_a);
      data_b = 32'hB000_0000 + 32'(beat_b);
      last_a = (beat_a == 9);
      last_b = (beat_b == 1);
      req_b  = (beat_b < 2);
      #1;
      n_checks++;
      if ({grant_a, grant_b} !== (exp_a[c] ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL limit_cycle%0d: ga gb=%b, want %b",
                 c, {grant_a, grant_b}, exp_a[c] ? 2'b10 : 2'b01);
      end
      if (c == 7) begin
        n_checks++;
        if (out_data !== 32'hA000_0004) begin
          n_fail++;
          $display("FAIL limit_resume_beat: data=%h, want a0000004", out_data);
        end
      end
      if (exp_a[c]) beat_a++;
      else beat_b++;
    end
    req_a = 0; req_b = 0; last_a = 0; last_b = 0;
  endtask
`endif

  initial begin
    rst = 1;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_stall();
    test_req_drop();
    test_async_reset();
`ifdef ARB_BURST_LIMIT_EN
    test_burst_limit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
